// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: active-high abcdefg encodings (a = bit 6),
// the blank digit code and the scan-reader state encoding.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h7E;
    localparam logic [6:0] SEG_1     = 7'h30;
    localparam logic [6:0] SEG_2     = 7'h6D;
    localparam logic [6:0] SEG_3     = 7'h79;
    localparam logic [6:0] SEG_4     = 7'h33;
    localparam logic [6:0] SEG_5     = 7'h5B;
    localparam logic [6:0] SEG_6     = 7'h5F;
    localparam logic [6:0] SEG_7     = 7'h70;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h7B;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [3:0] DIGIT_BLANK = 4'hF;

    typedef enum logic {
        ACQUIRE = 1'b0,
        HOLD    = 1'b1
    } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational seven-segment to BCD decoder. Anything that is not a legal
// digit reports DIGIT_BLANK; blank is flagged separately from illegal.
module seg7_pattern_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg,
    output logic       legal,
    output logic       blank,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b1;
        blank = 1'b0;
        bcd   = DIGIT_BLANK;
        case (seg)
            SEG_0: bcd = 4'd0;
            SEG_1: bcd = 4'd1;
            SEG_2: bcd = 4'd2;
            SEG_3: bcd = 4'd3;
            SEG_4: bcd = 4'd4;
            SEG_5: bcd = 4'd5;
            SEG_6: bcd = 4'd6;
            SEG_7: bcd = 4'd7;
            SEG_8: bcd = 4'd8;
            SEG_9: bcd = 4'd9;
            SEG_BLANK: begin
                legal = 1'b0;
                blank = 1'b1;
            end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg7_scan_reader.sv
// Receive side of a multiplexed seven-segment bus: debounces each strobe/pattern
// pair and latches the decoded BCD value into the strobed digit slot.
//
// state   | meaning
// ACQUIRE | input stable for fewer than STABLE_CYCLES edges, still counting
// HOLD    | current pair already evaluated; wait for the input to change
module seg7_scan_reader
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
)
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [6:0]              seg_in,
    input  logic [NUM_DIGITS-1:0]   dig_en,
    output logic [4*NUM_DIGITS-1:0] digit_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    pattern_err
);

    localparam int SW    = NUM_DIGITS + 7;
    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LATCH = CNT_W'(STABLE_CYCLES - 1);

    state_t                    state_q, state_d;
    logic [SW-1:0]             raw;
    logic [SW-1:0]             sample_q, sample_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0]     dig_q;
    logic [6:0]                seg_q;
    logic                      dig_onehot;
    logic                      latch;

    logic                      dec_legal;
    logic                      dec_blank;
    logic [3:0]                dec_bcd;

    logic [NUM_DIGITS-1:0]     seen_q;
    logic [NUM_DIGITS-1:0]     seen_set;
    logic                      frame_hit;

    logic [4*NUM_DIGITS-1:0]   digit_q;
    logic [NUM_DIGITS-1:0]     valid_q;
    logic                      frame_done_q;
    logic                      pattern_err_q;

    assign raw        = {dig_en, seg_in};
    assign dig_q      = sample_q[SW-1:7];
    assign seg_q      = sample_q[6:0];
    assign dig_onehot = $onehot(dig_q);

    seg7_pattern_decode u_decode (
        .seg   (seg_q),
        .legal (dec_legal),
        .blank (dec_blank),
        .bcd   (dec_bcd)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ACQUIRE;
            sample_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            sample_q <= sample_d;
            cnt_q    <= cnt_d;
        end
    end

    // A non-one-hot strobe still moves to HOLD so it is evaluated only once.
    always_comb begin
        state_d  = state_q;
        sample_d = sample_q;
        cnt_d    = cnt_q;
        latch    = 1'b0;
        if (raw != sample_q) begin
            sample_d = raw;
            cnt_d    = '0;
            state_d  = ACQUIRE;
        end else begin
            if (cnt_q < CNT_SAT) begin
                cnt_d = cnt_q + 1'b1;
            end
            if (state_q == ACQUIRE && cnt_q == CNT_LATCH) begin
                state_d = HOLD;
                latch   = dig_onehot;
            end
        end
    end

    assign seen_set  = seen_q | dig_q;
    assign frame_hit = latch && (&seen_set);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_q       <= {NUM_DIGITS{DIGIT_BLANK}};
            valid_q       <= '0;
            seen_q        <= '0;
            frame_done_q  <= 1'b0;
            pattern_err_q <= 1'b0;
        end else begin
            frame_done_q  <= frame_hit;
            pattern_err_q <= latch && !dec_legal && !dec_blank;
            if (latch) begin
                seen_q <= frame_hit ? '0 : seen_set;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (latch && dig_q[i]) begin
                    digit_q[4*i +: 4] <= dec_bcd;
                    valid_q[i]        <= dec_legal;
                end
            end
        end
    end

    assign digit_out   = digit_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed bench for seg7_scan_reader with default parameters (4 digits,
// 4-cycle stability window).
module tb_seg7_scan_reader;

    logic        clk;
    logic        rst;
    logic [6:0]  seg_in;
    logic [3:0]  dig_en;
    logic [15:0] digit_out;
    logic [3:0]  digit_valid;
    logic        frame_done;
    logic        pattern_err;

    int n_cmp;
    int n_bad;
    int fd_cnt;
    int pe_cnt;

    seg7_scan_reader #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .seg_in      (seg_in),
        .dig_en      (dig_en),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .pattern_err (pattern_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulses counted mid-cycle; a one-cycle pulse increments exactly once.
    always @(negedge clk) begin
        if (frame_done)  fd_cnt++;
        if (pattern_err) pe_cnt++;
    end

    task automatic hold_pattern(input logic [3:0] d, input logic [6:0] s, input int n);
        @(negedge clk);
        dig_en = d;
        seg_in = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        int fd0, pe0;
        rst = 1'b1;
        dig_en = 4'h0;
        seg_in = 7'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (digit_out !== 16'hFFFF) begin
            n_bad++;
            $display("FAIL reset_digit_out: got %h expected %h", digit_out, 16'hFFFF);
        end
        n_cmp++;
        if (digit_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_digit_valid: got %h expected %h", digit_valid, 4'h0);
        end
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        repeat (20) @(posedge clk);
        #1;
        n_cmp++;
        if (digit_out !== 16'hFFFF || digit_valid !== 4'h0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %h/%h expected FFFF/0", digit_out, digit_valid);
        end
        n_cmp++;
        if (fd_cnt - fd0 !== 0 || pe_cnt - pe0 !== 0) begin
            n_bad++;
            $display("FAIL idle_pulses: got fd=%0d pe=%0d expected 0/0", fd_cnt - fd0, pe_cnt - pe0);
        end
    endtask

    task automatic test_single_latch();
        int fd0, pe0;
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        @(negedge clk);
        dig_en = 4'b0001;
        seg_in = 7'h6D;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                n_cmp++;
                if (digit_out !== 16'hFFFF || digit_valid !== 4'h0) begin
                    n_bad++;
                    $display("FAIL early_latch_edge%0d: got %h/%h expected FFFF/0", k, digit_out, digit_valid);
                end
            end else begin
                n_cmp++;
                if (digit_out !== 16'hFFF2 || digit_valid !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL latch_edge4: got %h/%h expected FFF2/1", digit_out, digit_valid);
                end
            end
        end
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if (digit_out !== 16'hFFF2 || digit_valid !== 4'b0001 || fd_cnt != fd0 || pe_cnt != pe0) begin
            n_bad++;
            $display("FAIL hold_no_relatch: got %h/%h fd=%0d pe=%0d expected FFF2/1 0/0",
                     digit_out, digit_valid, fd_cnt - fd0, pe_cnt - pe0);
        end
    endtask

    task automatic test_scan();
        int fd0;
        logic [3:0] d_tab [4];
        logic [6:0] s_tab [4];
        d_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        s_tab = '{7'h7E, 7'h30, 7'h79, 7'h7B};
        fd0 = fd_cnt;
        for (int k = 0; k < 4; k++) begin
            hold_pattern(d_tab[k], s_tab[k], 6);
            n_cmp++;
            if (fd_cnt - fd0 !== (k == 3 ? 1 : 0)) begin
                n_bad++;
                $display("FAIL scan_frame_done_step%0d: got %0d expected %0d", k, fd_cnt - fd0, (k == 3 ? 1 : 0));
            end
        end
        n_cmp++;
        if (digit_out !== 16'h9310 || digit_valid !== 4'hF) begin
            n_bad++;
            $display("FAIL scan_digits: got %h/%h expected 9310/F", digit_out, digit_valid);
        end
    endtask

    task automatic test_pattern_err();
        int pe0;
        pe0 = pe_cnt;
        hold_pattern(4'b0010, 7'h01, 6);
        n_cmp++;
        if (pe_cnt - pe0 !== 1) begin
            n_bad++;
            $display("FAIL illegal_err_pulses: got %0d expected 1", pe_cnt - pe0);
        end
        n_cmp++;
        if (digit_out !== 16'h93F0 || digit_valid !== 4'b1101) begin
            n_bad++;
            $display("FAIL illegal_digit: got %h/%h expected 93F0/D", digit_out, digit_valid);
        end
        hold_pattern(4'b0010, 7'h00, 6);
        n_cmp++;
        if (pe_cnt - pe0 !== 1) begin
            n_bad++;
            $display("FAIL blank_no_err: got %0d expected 1", pe_cnt - pe0);
        end
        n_cmp++;
        if (digit_out !== 16'h93F0 || digit_valid !== 4'b1101) begin
            n_bad++;
            $display("FAIL blank_digit: got %h/%h expected 93F0/D", digit_out, digit_valid);
        end
    endtask

    // Mask was cleared by the last frame; only digit 1 is seen at this point.
    task automatic test_frame_restart();
        int fd0;
        fd0 = fd_cnt;
        hold_pattern(4'b0001, 7'h7F, 6);
        hold_pattern(4'b0100, 7'h5F, 6);
        n_cmp++;
        if (fd_cnt - fd0 !== 0) begin
            n_bad++;
            $display("FAIL restart_early_frame: got %0d expected 0", fd_cnt - fd0);
        end
        hold_pattern(4'b1000, 7'h33, 6);
        n_cmp++;
        if (fd_cnt - fd0 !== 1) begin
            n_bad++;
            $display("FAIL restart_frame: got %0d expected 1", fd_cnt - fd0);
        end
        n_cmp++;
        if (digit_out !== 16'h46F8 || digit_valid !== 4'b1101) begin
            n_bad++;
            $display("FAIL restart_digits: got %h/%h expected 46F8/D", digit_out, digit_valid);
        end
    endtask

    task automatic test_glitch();
        int fd0, pe0;
        fd0 = fd_cnt;
        pe0 = pe_cnt;
        for (int k = 0; k < 3; k++) begin
            hold_pattern(4'b0001, 7'h30, 3);
            hold_pattern(4'b0001, 7'h31, 1);
        end
        n_cmp++;
        if (digit_out !== 16'h46F8 || digit_valid !== 4'b1101 || fd_cnt != fd0 || pe_cnt != pe0) begin
            n_bad++;
            $display("FAIL glitch_no_latch: got %h/%h fd=%0d pe=%0d expected 46F8/D 0/0",
                     digit_out, digit_valid, fd_cnt - fd0, pe_cnt - pe0);
        end
        hold_pattern(4'b0011, 7'h30, 10);
        n_cmp++;
        if (digit_out !== 16'h46F8 || digit_valid !== 4'b1101 || fd_cnt != fd0 || pe_cnt != pe0) begin
            n_bad++;
            $display("FAIL multihot_no_latch: got %h/%h fd=%0d pe=%0d expected 46F8/D 0/0",
                     digit_out, digit_valid, fd_cnt - fd0, pe_cnt - pe0);
        end
    endtask

    task automatic test_reset_mid();
        int fd0;
        hold_pattern(4'b0100, 7'h6D, 3);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (digit_out !== 16'hFFFF || digit_valid !== 4'h0 || frame_done !== 1'b0 || pattern_err !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_reset_outputs: got %h/%h fd=%b pe=%b expected FFFF/0 0/0",
                     digit_out, digit_valid, frame_done, pattern_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fd0 = fd_cnt;
        for (int k = 0; k <= 4; k++) begin
            @(posedge clk);
            #1;
            if (k < 4) begin
                n_cmp++;
                if (digit_out !== 16'hFFFF || digit_valid !== 4'h0) begin
                    n_bad++;
                    $display("FAIL post_reset_stale_edge%0d: got %h/%h expected FFFF/0", k, digit_out, digit_valid);
                end
            end else begin
                n_cmp++;
                if (digit_out !== 16'hF2FF || digit_valid !== 4'b0100 || fd_cnt != fd0) begin
                    n_bad++;
                    $display("FAIL post_reset_latch: got %h/%h fd=%0d expected F2FF/4 0",
                             digit_out, digit_valid, fd_cnt - fd0);
                end
            end
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        fd_cnt = 0;
        pe_cnt = 0;
        rst    = 1'b1;
        dig_en = 4'h0;
        seg_in = 7'h00;
        test_reset();
        test_single_latch();
        test_scan();
        test_pattern_err();
        test_frame_restart();
        test_glitch();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Sequential reader for a multiplexed, active-high seven-segment display bus: samples the segment lines together with the one-hot digit strobe, waits for each strobe/pattern pair to hold stable, and decodes it back to BCD. It is the receive end of the segment-encoder path: it recovers digit values from what the display drivers emit. Outputs are a registered BCD digit array, per-digit valid flags, a frame-complete pulse and an invalid-pattern pulse.

## Interface
- NUM_DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 4: consecutive matching samples required before latch (1..255).
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- seg_in  input  7  segment lines {a,b,c,d,e,f,g}, a = bit 6, g = bit 0, 1 = lit.
- dig_en  input  NUM_DIGITS  digit strobe, one-hot active-high; bit i selects digit i.
- digit_out  output  4*NUM_DIGITS  BCD per digit; digit i in bits [4i+3:4i]; 4'hF = blank/invalid.
- digit_valid  output  NUM_DIGITS  bit i = 1 when digit i last latched a legal 0–9 pattern.
- frame_done  output  1  one-cycle pulse when every digit has latched since the last pulse.
- pattern_err  output  1  one-cycle pulse when a latched pattern is neither 0–9 nor blank.

## Operation
- Legal patterns (hex, abcdefg): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B; blank=00.
- Sample register sample_q holds {dig_en, seg_in}; stability counter cnt of width clog2(STABLE_CYCLES+1).
- Each edge: raw input != sample_q -> sample_q <= input, cnt <= 0, state <= ACQUIRE. Equal -> cnt increments, saturating.
- States: ACQUIRE (counting), HOLD (latched, waiting for the input to change). HOLD -> ACQUIRE only on an input change.
- Latch: in ACQUIRE, input equals sample_q, cnt == STABLE_CYCLES-1, and sample_q.dig_en is exactly one-hot. On latch: state <= HOLD and digit i is updated.
  - Legal digit: digit_out[i] <= BCD, digit_valid[i] <= 1.
  - Blank: digit_out[i] <= F, digit_valid[i] <= 0, no error.
  - Illegal pattern: digit_out[i] <= F, digit_valid[i] <= 0, pattern_err pulses.
- dig_en zero or multi-hot: no latch, no error. State goes to HOLD once the count is reached, so there is no repeated evaluation.
- seen mask (NUM_DIGITS bits): the latch sets bit i. If the mask including bit i is all ones, frame_done pulses and the mask clears to zero in the same edge; bit i is not left set.
- Re-latching an already-seen digit before the frame completes overwrites its value; the mask is unchanged.
- Reset mid-acquire discards any partial count; no stale latch after reset release.

## Timing
- Input changes before edge 0 -> captured at edge 0 (cnt=0); held through edge STABLE_CYCLES -> latch at edge STABLE_CYCLES.
  - digit_out, digit_valid, frame_done and pattern_err are visible after that edge.
- STABLE_CYCLES=4 -> latency of 4 edges after capture. STABLE_CYCLES=1 -> latch on the first edge after capture.
- A glitch of any length resets the count. A pattern held shorter than STABLE_CYCLES+1 edges never latches.
- All outputs are registered; frame_done and pattern_err are high for exactly one cycle per event.
- Reset values: digit_out all 4'hF, digit_valid 0, frame_done 0, pattern_err 0, sample_q 0, cnt 0, seen 0, state ACQUIRE.

## Structure
- Package seg7_pkg:
  - constants SEG_0..SEG_9 and SEG_BLANK (7-bit);
  - DIGIT_BLANK = 4'hF;
  - state enum {ACQUIRE, HOLD}.
- Sub-module seg7_pattern_decode, purely combinational: seg[6:0] -> {legal, blank, bcd[3:0]}. Instantiated once on sample_q.seg_in. Shared with other segment blocks.
- Top holds the sample register, counter, FSM, one-hot check, seen mask and output registers.

## Test plan
- Reset, then idle inputs -> digit_out=16'hFFFF, digit_valid=0, no pulses for 20 cycles.
- Defaults; dig_en=0001, seg_in=7'h6D held 6 edges -> digit 0 = 2 and digit_valid[0]=1 exactly at edge 4 after capture; no relatch while held.
- Scan digits 0..3 with patterns 7E, 30, 79, 7B, each held 6 cycles -> digit_out=16'h9310, digit_valid=4'hF, one frame_done pulse on the last latch, seen mask cleared.
- dig_en=0010, seg_in=7'h01 held -> pattern_err pulses once, digit_out[7:4]=F, digit_valid[1]=0. Then seg_in=7'h00 -> blank, no pattern_err.
- Patterns held 3 cycles, alternating with 1-cycle glitches -> no latch, outputs unchanged. dig_en=0011 held 10 cycles -> no latch, no error.
- Assert rst during ACQUIRE (cnt=2) -> all outputs return to reset values immediately. After release, a latch needs a full fresh STABLE_CYCLES hold.
